product_bcd_converter: RTL and testbench

Downstream stage of the 8-bit signed shift-add multiplier. On a Start pulse it captures the 16-bit two's-complement product {A, B}, splits it into a sign flag and a magnitude, and converts the magnitude to packed BCD with a sequential double-dabble engine, one iteration per clock. Its digit outputs drive the hex display path, so the product is shown in decimal instead of raw hex.

---
 rtl/product_bcd_converter.sv | 137 +++++++++++++
 tb/tb_product_bcd_converter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/product_bcd_converter.sv
// Signed product to sign + packed BCD magnitude, sequential double-dabble (one bit per clock).
// Optional leading-zero blank mask enabled by defining LEADING_ZERO_BLANK_EN.
module product_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      Product_In,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Neg,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [DIGITS-1:0]     Blank
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BW-1:0]   scr_q, scr_d;
    logic            neg_scr_q, neg_scr_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            neg_q, neg_d;

    logic [BW-1:0]       scr_adj;
    logic [BW+WIDTH-1:0] shifted;
    logic                last_iter;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign scr_adj[4*gi +: 4] = (scr_q[4*gi +: 4] >= 4'd5) ?
                                        (scr_q[4*gi +: 4] + 4'd3) : scr_q[4*gi +: 4];
        end
    endgenerate

    assign shifted   = {scr_adj, mag_q} << 1;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        scr_d     = scr_q;
        neg_scr_d = neg_scr_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    neg_scr_d = Product_In[WIDTH-1];
                    // 0x8000 negates to itself, which is exactly 2^(WIDTH-1) read as unsigned
                    mag_d     = Product_In[WIDTH-1] ? (~Product_In + WIDTH'(1)) : Product_In;
                    scr_d     = '0;
                    cnt_d     = '0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                scr_d = shifted[BW+WIDTH-1 -: BW];
                mag_d = shifted[WIDTH-1:0];
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    bcd_d   = shifted[BW+WIDTH-1 -: BW];
                    neg_d   = neg_scr_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mag_q     <= '0;
            scr_q     <= '0;
            neg_scr_q <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            scr_q     <= scr_d;
            neg_scr_q <= neg_scr_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
        end
    end

    assign Busy = (state_q != ST_IDLE);
    assign Done = (state_q == ST_DONE);
    assign Neg  = neg_q;
    assign BCD  = bcd_q;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;

    // Digit 0 is never blanked so a zero result still shows a single "0"
    assign blank_d[0] = 1'b0;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign blank_d[gi] = (bcd_d[BW-1:4*gi] == '0);
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign Blank = blank_q;
`else
    assign Blank = '0;
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
// Randomized self-checking bench for product_bcd_converter against an arithmetic decimal model.
module tb_product_bcd_converter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [15:0] Product_In;
    logic        Busy;
    logic        Done;
    logic        Neg;
    logic [19:0] BCD;
    logic [4:0]  Blank;

    int n_checks = 0;
    int n_pass   = 0;

    logic [19:0] prev_bcd;

    product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Product_In (Product_In),
        .Busy       (Busy),
        .Done       (Done),
        .Neg        (Neg),
        .BCD        (BCD),
        .Blank      (Blank)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Decimal reference: signed value -> sign, magnitude digits by repeated division
    task automatic model(input logic [15:0] p, output logic neg, output logic [19:0] bcd,
                         output logic [4:0] blank);
        int v;
        int m;
        v   = int'($signed(p));
        neg = (v < 0);
        m   = neg ? -v : v;
        bcd = '0;
        for (int d = 0; d < 5; d++) begin
            bcd[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 1; i < 5; i++) blank[i] = ((bcd >> (4*i)) == 20'd0);
`endif
    endtask

    // Called #1 after a posedge with the DUT idle; returns #1 after the capture edge
    task automatic launch(input logic [15:0] p);
        Start      = 1'b1;
        Product_In = p;
        @(posedge Clk); #1;
        Start      = 1'b0;
        Product_In = 16'($urandom);
        check("busy_after_capture", Busy, 1'b1);
    endtask

    // Waits for Done; returns #1 after the edge that raised it
    task automatic wait_done(input logic [15:0] p);
        logic        e_neg;
        logic [19:0] e_bcd;
        logic [4:0]  e_blank;
        int          k;
        model(p, e_neg, e_bcd, e_blank);
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge Clk); #1;
            k = c;
            if (Done) break;
            if (c == 15) begin
                check("bcd_held_during_conv", BCD, prev_bcd);
                check("busy_during_conv", Busy, 1'b1);
            end
        end
        check("latency", k, 16);
        check("done", Done, 1'b1);
        check("busy_in_done", Busy, 1'b1);
        check("neg", Neg, e_neg);
        check("bcd", BCD, e_bcd);
        check("blank", Blank, e_blank);
        $display("conv p=%04h neg=%0b bcd=%05h blank=%05b latency=%0d", p, Neg, BCD, Blank, k);
        prev_bcd = e_bcd;
    endtask

    // Leaves DONE, confirms one idle cycle, then starts the next conversion immediately
    task automatic convert(input logic [15:0] p);
        @(posedge Clk); #1;
        check("idle_busy", Busy, 1'b0);
        check("idle_done", Done, 1'b0);
        launch(p);
        wait_done(p);
    endtask

    initial begin
        logic [15:0] dir [5];
        int          pulses;
        int          first_k;
        dir[0] = 16'h0000; dir[1] = 16'hFFF1; dir[2] = 16'h8000;
        dir[3] = 16'h7FFF; dir[4] = 16'hFF38;

        Reset = 1'b1; Start = 1'b0; Product_In = '0; prev_bcd = '0;
        #12;
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_neg", Neg, 1'b0);
        check("rst_bcd", BCD, 20'h0);
        check("rst_blank", Blank, 5'h0);
        @(negedge Clk); Reset = 1'b0;
        @(posedge Clk); #1;
        launch(dir[0]);
        wait_done(dir[0]);

        for (int i = 1; i < 5; i++) convert(dir[i]);

        // Mid-conversion Start must be ignored
        @(posedge Clk); #1;
        launch(16'h3F01);
        pulses  = 0;
        first_k = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge Clk); #1;
            if (c == 4) begin Start = 1'b1; Product_In = 16'h0001; end
            if (c == 5) Start = 1'b0;
            if (Done) begin
                pulses++;
                if (first_k == 0) first_k = c;
            end
        end
        check("ignore_pulses", pulses, 1);
        check("ignore_latency", first_k, 16);
        check("ignore_bcd", BCD, 20'h16129);
        check("ignore_neg", Neg, 1'b0);
        $display("ignore p=3f01 pulses=%0d bcd=%05h", pulses, BCD);
        prev_bcd = 20'h16129;

        // Async reset in the middle of a conversion
        launch(16'hFF38);
        wait_done(16'hFF38);
        convert(16'h0000);
        @(posedge Clk); #1;
        launch(16'h1234);
        repeat (8) @(posedge Clk);
        #3 Reset = 1'b1;
        #1;
        check("abort_busy", Busy, 1'b0);
        check("abort_done", Done, 1'b0);
        check("abort_neg", Neg, 1'b0);
        check("abort_bcd", BCD, 20'h0);
        check("abort_blank", Blank, 5'h0);
        @(negedge Clk); Reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge Clk); #1;
            if (Done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        $display("abort p=1234 done_pulses=%0d", pulses);
        prev_bcd = '0;
        launch(16'h1234);
        wait_done(16'h1234);

        // Randomized back-to-back conversions
        for (int i = 0; i < 30; i++) convert(16'($urandom_range(0, 65535)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
